// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports,
// hard-wired zero register, optional write-to-read forwarding and error counting.
module reg_file_mp #(
   parameter int            DW      = 32,
   parameter int            DEPTH   = 32,
   parameter int            AW      = $clog2(DEPTH),
   parameter int            NUM_RD  = 2,
   parameter int            BYPASS  = 1,
   parameter int            SP_ADDR = 29,
   parameter logic [DW-1:0] SP_INIT = 32'h0000_0400
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_RD*AW-1:0] raddr_i,
   output logic [NUM_RD*DW-1:0] rdata_o,
   input  logic [1:0]           we_i,
   input  logic [2*AW-1:0]      waddr_i,
   input  logic [2*DW-1:0]      wdata_i,
   input  logic                 jr_i,
   output logic                 err_zero_o,
   output logic                 err_conflict_o,
   output logic [7:0]           err_cnt_o
);

   logic [DW-1:0] regs [DEPTH];

   logic [AW-1:0] waddr0;
   logic [AW-1:0] waddr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          wr_en0;
   logic          wr_en1;
   logic          zero_hit;
   logic          conflict_hit;
   logic [1:0]    err_inc;

   function automatic logic [7:0] sat_cnt(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   assign waddr0 = waddr_i[0 +: AW];
   assign waddr1 = waddr_i[AW +: AW];
   assign wdata0 = wdata_i[0 +: DW];
   assign wdata1 = wdata_i[DW +: DW];

   // Effective writes exclude register 0, which is never stored.
   assign wr_en0 = we_i[0] && (waddr0 != '0);
   assign wr_en1 = we_i[1] && (waddr1 != '0);

   // Both ports aiming at register 0 still count as a single zero-write event.
   assign zero_hit     = !jr_i && ((we_i[0] && (waddr0 == '0)) || (we_i[1] && (waddr1 == '0)));
   assign conflict_hit = wr_en0 && wr_en1 && (waddr0 == waddr1);
   assign err_inc      = {1'b0, zero_hit} + {1'b0, conflict_hit};

   // Port 1 is applied last so it wins a same-address collision.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= (i == SP_ADDR) ? SP_INIT : '0;
         end
      end else begin
         if (wr_en0) regs[waddr0] <= wdata0;
         if (wr_en1) regs[waddr1] <= wdata1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_zero_o     <= 1'b0;
         err_conflict_o <= 1'b0;
         err_cnt_o      <= 8'd0;
      end else begin
         err_zero_o     <= zero_hit;
         err_conflict_o <= conflict_hit;
         err_cnt_o      <= sat_cnt(err_cnt_o, err_inc);
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;

      assign ra = raddr_i[k*AW +: AW];

      // Later assignments take precedence: port 1 forwarding over port 0, zero over all.
      always_comb begin
         rd = regs[ra];
         if ((BYPASS != 0) && wr_en0 && (waddr0 == ra)) rd = wdata0;
         if ((BYPASS != 0) && wr_en1 && (waddr1 == ra)) rd = wdata1;
         if (ra == '0) rd = '0;
      end

      assign rdata_o[k*DW +: DW] = rd;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a forwarding instance and a non-forwarding
// instance share stimulus; expectations come from a behavioural register model.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 32;
   localparam logic [31:0] SP_INIT = 32'h0000_0400;

   localparam int SEL_RD0 = 0;
   localparam int SEL_RD1 = 1;
   localparam int SEL_EZ  = 2;
   localparam int SEL_EC  = 3;
   localparam int SEL_CNT = 4;
   localparam int SEL_NB0 = 5;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [1:0]    we;
   logic [AW-1:0] a0, a1, r0, r1;
   logic [DW-1:0] d0, d1;
   logic          jr;

   logic [2*AW-1:0] raddr, waddr;
   logic [2*DW-1:0] wdata, rdata, rdata_nb;
   logic            ez, ec, ez_nb, ec_nb;
   logic [7:0]      cnt, cnt_nb;

   assign raddr = {r1, r0};
   assign waddr = {a1, a0};
   assign wdata = {d1, d0};

   always #5 clk_i = ~clk_i;

   reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(2), .BYPASS(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr), .rdata_o(rdata),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .jr_i(jr),
      .err_zero_o(ez), .err_conflict_o(ec), .err_cnt_o(cnt)
   );

   reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(2), .BYPASS(0)) dut_nb (
      .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr), .rdata_o(rdata_nb),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .jr_i(jr),
      .err_zero_o(ez_nb), .err_conflict_o(ec_nb), .err_cnt_o(cnt_nb)
   );

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] mregs [DEPTH];
   int          mcnt;
   exp_t        comb_q[$];
   exp_t        reg_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] obs_of(input int sel);
      case (sel)
         SEL_RD0: return rdata[0 +: DW];
         SEL_RD1: return rdata[DW +: DW];
         SEL_EZ:  return {31'b0, ez};
         SEL_EC:  return {31'b0, ec};
         SEL_CNT: return {24'b0, cnt};
         default: return rdata_nb[0 +: DW];
      endcase
   endfunction

   task automatic push_c(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = v;
      comb_q.push_back(e);
   endtask

   task automatic push_r(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = v;
      reg_q.push_back(e);
   endtask

   task automatic drain_c();
      exp_t e;
      while (comb_q.size() > 0) begin
         e = comb_q.pop_front();
         check_val(e.tag, obs_of(e.sel), e.exp);
      end
   endtask

   task automatic drain_r();
      exp_t e;
      while (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         check_val(e.tag, obs_of(e.sel), e.exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [AW-1:0] ra, input bit fwd);
      if (ra == 0) return 32'h0;
      if (fwd && we[1] && a1 == ra && a1 != 0) return d1;
      if (fwd && we[0] && a0 == ra && a0 != 0) return d0;
      return mregs[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mregs[i] = (i == 29) ? SP_INIT : 32'h0;
      mcnt = 0;
   endtask

   // One clock of stimulus; entered and left 1 time unit after a rising edge.
   task automatic cycle(input logic [1:0] w, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                        input logic [AW-1:0] wa1, input logic [DW-1:0] wd1, input logic j,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      bit exp_ez, exp_ec;
      we = w; a0 = wa0; d0 = wd0; a1 = wa1; d1 = wd1; jr = j; r0 = ra0; r1 = ra1;
      #2;
      push_c("rd0", SEL_RD0, model_rd(r0, 1'b1));
      push_c("rd1", SEL_RD1, model_rd(r1, 1'b1));
      push_c("nb_rd0", SEL_NB0, model_rd(r0, 1'b0));
      drain_c();
      exp_ez = !j && ((w[0] && wa0 == 0) || (w[1] && wa1 == 0));
      exp_ec = (w == 2'b11) && (wa0 == wa1) && (wa0 != 0);
      mcnt = mcnt + int'(exp_ez) + int'(exp_ec);
      if (mcnt > 255) mcnt = 255;
      push_r("err_zero", SEL_EZ, {31'b0, exp_ez});
      push_r("err_conf", SEL_EC, {31'b0, exp_ec});
      push_r("err_cnt", SEL_CNT, mcnt);
      @(posedge clk_i);
      #1;
      if (w[0] && wa0 != 0) mregs[wa0] = wd0;
      if (w[1] && wa1 != 0) mregs[wa1] = wd1;
      drain_r();
   endtask

   task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      cycle(2'b00, 0, 0, 0, 0, 1'b0, ra0, ra1);
   endtask

   initial begin
      rst_i = 1'b0;
      we = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; jr = 0; r0 = 29; r1 = 5;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_val("rst_sp", rdata[0 +: DW], SP_INIT);
      check_val("rst_r5", rdata[DW +: DW], 32'h0);
      check_val("rst_ez", {31'b0, ez}, 32'h0);
      check_val("rst_ec", {31'b0, ec}, 32'h0);
      check_val("rst_cnt", {24'b0, cnt}, 32'h0);
      rst_i = 1'b1;

      // Same-cycle forwarding versus stored value
      we = 2'b01; a0 = 3; d0 = 32'hDEAD_BEEF; r0 = 3; r1 = 29;
      #2;
      check_val("fwd_lit", rdata[0 +: DW], 32'hDEAD_BEEF);
      check_val("nofwd_lit", rdata_nb[0 +: DW], 32'h0);
      cycle(2'b01, 3, 32'hDEAD_BEEF, 0, 0, 1'b0, 3, 29);
      idle(3, 29);
      check_val("stored_lit", rdata[0 +: DW], 32'hDEAD_BEEF);

      // Write conflict: port 1 wins, one-cycle flag
      cycle(2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 7, 0);
      check_val("conf_lit", {31'b0, ec}, 32'h1);
      check_val("conf_cnt_lit", {24'b0, cnt}, 32'h1);
      idle(7, 3);
      check_val("r7_lit", rdata[0 +: DW], 32'h2);

      // Register 0 writes: error without jr, benign with jr
      cycle(2'b01, 0, 32'h5, 0, 0, 1'b0, 0, 7);
      check_val("zero_lit", {31'b0, ez}, 32'h1);
      cycle(2'b01, 0, 32'h5, 0, 0, 1'b1, 0, 7);
      check_val("jr_cnt_lit", {24'b0, cnt}, 32'h2);
      cycle(2'b11, 0, 32'h9, 0, 32'hA, 1'b0, 0, 0);
      check_val("dual_zero_cnt", {24'b0, cnt}, 32'h3);

      // Disabled ports are ignored entirely
      cycle(2'b10, 0, 32'h0, 4, 32'h4444_0004, 1'b0, 4, 0);
      cycle(2'b00, 4, 32'hBAD0_BAD0, 4, 32'hBAD1_BAD1, 1'b0, 4, 4);
      cycle(2'b01, 10, 32'hAAAA_5555, 0, 32'h0, 1'b0, 10, 29);

      for (int i = 0; i < 40; i++) begin
         cycle(2'($urandom_range(0, 3)), 5'($urandom_range(0, 11)), $urandom,
               5'($urandom_range(0, 11)), $urandom, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      end
      cycle(2'b01, 10, 32'hAAAA_5555, 0, 32'h0, 1'b0, 10, 29);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) cycle(2'b01, 0, i, 0, 0, 1'b0, 10, 29);
      check_val("sat_lit", {24'b0, cnt}, 32'd255);

      // Asynchronous reset in the middle of a write to register 10
      we = 2'b01; a0 = 10; d0 = 32'h1234_5678; a1 = 0; d1 = 0; jr = 0; r0 = 10; r1 = 29;
      #2;
      rst_i = 1'b0;
      #1;
      model_reset();
      check_val("arst_ez", {31'b0, ez}, 32'h0);
      check_val("arst_cnt", {24'b0, cnt}, 32'h0);
      check_val("arst_sp", rdata[DW +: DW], SP_INIT);
      check_val("arst_r10_nb", rdata_nb[0 +: DW], 32'h0);
      @(posedge clk_i);
      #1;
      we = 2'b00;
      #1;
      check_val("arst_r10", rdata[0 +: DW], 32'h0);
      check_val("arst_ec", {31'b0, ec}, 32'h0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      cycle(2'b01, 10, 32'h0BAD_F00D, 0, 0, 1'b0, 10, 29);
      idle(10, 29);
      check_val("resume_r10", rdata[0 +: DW], 32'h0BAD_F00D);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of 2, >= 4).
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have parameter SP_ADDR, default 29, stack-pointer register index.
REQ-007 SHALL have parameter SP_INIT, default 32'h0000_0400, reset value of SP_ADDR.
REQ-008 SHALL have port clk_i input 1: single clock, rising edge.
REQ-009 SHALL have port rst_i input 1: asynchronous active-low reset.
REQ-010 SHALL have port raddr_i input NUM_RD*AW: packed read addresses, port k at [k*AW +: AW].
REQ-011 SHALL have port rdata_o output NUM_RD*DW: packed read data, port k at [k*DW +: DW].
REQ-012 SHALL have port we_i input 2: write enables, bit k for write port k.
REQ-013 SHALL have port waddr_i input 2*AW: packed write addresses.
REQ-014 SHALL have port wdata_i input 2*DW: packed write data.
REQ-015 SHALL have port jr_i input 1: when 1, a write to address 0 is benign (no error).
REQ-016 SHALL have port err_zero_o output 1: registered one-cycle pulse, illegal write to register 0.
REQ-017 SHALL have port err_conflict_o output 1: registered one-cycle pulse, both write ports hit same nonzero address.
REQ-018 SHALL have port err_cnt_o output 8: saturating count of error events.

Function
REQ-019 SHALL return 0 on any read port whose address is 0, regardless of writes.
REQ-020 SHALL read combinationally: rdata for port k = register[raddr k] when no bypass applies.
REQ-021 SHALL, when BYPASS=1, return wdata of write port p if we_i[p]=1 and waddr p = raddr k != 0; port 1 takes priority over port 0.
REQ-022 SHALL, when BYPASS=0, return only the stored (pre-edge) value.
REQ-023 SHALL write wdata p to register[waddr p] on rising clk_i when we_i[p]=1 and waddr p != 0.
REQ-024 SHALL, when both ports write the same nonzero address in one cycle, store port 1 data and set err_conflict_o=1 for exactly the following cycle.
REQ-025 SHALL never modify register 0; a write to address 0 with jr_i=0 sets err_zero_o=1 for exactly the following cycle.
REQ-026 SHALL raise err_zero_o once per cycle even if both ports target address 0 with jr_i=0.
REQ-027 SHALL produce no error for address-0 writes when jr_i=1.
REQ-028 SHALL increment err_cnt_o at the rising edge by the number of error flags asserted that edge (0, 1 or 2), saturating at 255.
REQ-029 SHALL ignore waddr_i/wdata_i of a port whose we_i bit is 0 (no write, no error, no bypass).
REQ-030 SHALL hold all register contents when no write is enabled.

Reset
REQ-031 SHALL, while rst_i=0, force all registers to 0 except register SP_ADDR = SP_INIT, independent of clk_i.
REQ-032 SHALL, while rst_i=0, force err_zero_o=0, err_conflict_o=0, err_cnt_o=0.
REQ-033 SHALL give reset priority over any simultaneous write; no write completes at an edge where rst_i=0.
REQ-034 SHALL resume normal writes at the first rising clk_i after rst_i returns to 1.

Verification
REQ-035 SHALL cover: release reset, read addr 29 and addr 5 -> 32'h0000_0400 and 0.
REQ-036 SHALL cover: we=01, waddr0=3, wdata0=32'hDEAD_BEEF, raddr0=3 same cycle -> rdata0=DEAD_BEEF (BYPASS=1); next cycle stored value DEAD_BEEF; with BYPASS=0 same-cycle read returns old value 0.
REQ-037 SHALL cover: we=11, both waddr=7, wdata0=1, wdata1=2 -> register 7 = 2, err_conflict_o=1 one cycle, err_cnt_o=1.
REQ-038 SHALL cover: we=01, waddr0=0, wdata0=5, jr_i=0 -> reg 0 reads 0, err_zero_o=1 one cycle, err_cnt +1; repeat with jr_i=1 -> no error, count unchanged.
REQ-039 SHALL cover: 300 consecutive zero-write cycles -> err_cnt_o saturates at 255 and holds.
REQ-040 SHALL cover: assert rst_i=0 mid-cycle during a write to register 10 -> register 10 = 0, flags and count 0 immediately, SP_ADDR = SP_INIT.
